// File: rtl/rgmii_rx_assembler.sv
// ---------------------------------------------------------------------------
// rgmii_rx_assembler
//
// Rebuilds a GMII-style byte stream from the per-cycle rising/falling-edge
// samples of the RGMII receive DDR input stage. It supports 1000 Mb/s (one
// byte per clock from both edges) and 10/100 Mb/s (one nibble per clock,
// taken from the rising-edge sample). RX_DV/RX_ER are decoded from RX_CTL.
//
// Ports:
//   clk          recovered RGMII RX clock
//   rst          synchronous, active-high reset
//   rx_q1        rising-edge sample  {ctl, d[3:0]}
//   rx_q2        falling-edge sample {ctl, d[3:0]}
//   speed        00=10M, 01=100M, 10=1G, 11=1G
//   gmii_rxd     assembled byte
//   gmii_rx_dv   data valid for the current byte
//   gmii_rx_er   receive error for the current byte
//   gmii_rx_v    byte strobe; byte outputs meaningful only when 1
//   nib_err      one-cycle pulse when a frame ends on an odd nibble
//   nib_err_cnt  saturating count of nib_err pulses
//   link_up      in-band link status      (optional)
//   link_speed   in-band speed            (optional)
//   full_duplex  in-band duplex           (optional)
//
// Optional feature macro: RGMII_RX_INBAND_STATUS_EN
//   Defined   : in-band status is decoded from idle cycles and registered
//               after two consecutive identical samples.
//   Undefined : link_up, link_speed and full_duplex are tied to 0.
// ---------------------------------------------------------------------------
module rgmii_rx_assembler #(
    parameter int NIB_ERR_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               rx_q1,
    input  logic [4:0]               rx_q2,
    input  logic [1:0]               speed,
    output logic [7:0]               gmii_rxd,
    output logic                     gmii_rx_dv,
    output logic                     gmii_rx_er,
    output logic                     gmii_rx_v,
    output logic                     nib_err,
    output logic [NIB_ERR_CNT_W-1:0] nib_err_cnt,
    output logic                     link_up,
    output logic [1:0]               link_speed,
    output logic                     full_duplex
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW
    } state_t;

    function automatic logic [NIB_ERR_CNT_W-1:0] sat_inc(
        input logic [NIB_ERR_CNT_W-1:0] val
    );
        if (&val) return val;
        return val + {{(NIB_ERR_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // ---- stage p0: per-cycle decode of the DDR samples ----
    logic       dv_p0;
    logic       er_p0;
    logic [3:0] nib_p0;

    assign dv_p0  = rx_q1[4];
    assign er_p0  = rx_q1[4] ^ rx_q2[4];
    assign nib_p0 = rx_q1[3:0];

    state_t     state;
    logic [1:0] active_speed;
    logic       dv_reg;
    logic [3:0] low_nib_p1;
    logic       low_er_p1;
    logic       gig_mode;

    assign gig_mode = (active_speed == 2'b10) || (active_speed == 2'b11);

    // ---- stage p1: registered assembly and outputs ----
    // The reset state is IDLE; IDLE and LOW both expect a low nibble next and
    // react identically, so they only differ in name for readability.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            active_speed <= 2'b10;
            dv_reg       <= 1'b0;
            gmii_rxd     <= 8'h00;
            gmii_rx_dv   <= 1'b0;
            gmii_rx_er   <= 1'b0;
            gmii_rx_v    <= 1'b0;
            nib_err      <= 1'b0;
            nib_err_cnt  <= '0;
        end else begin
            dv_reg  <= dv_p0;
            nib_err <= 1'b0;
            // Speed only follows the input between frames, so a mid-frame
            // change takes effect once the frame has ended.
            if (!dv_reg) active_speed <= speed;

            if (gig_mode) begin
                gmii_rxd   <= {rx_q2[3:0], rx_q1[3:0]};
                gmii_rx_dv <= dv_p0;
                gmii_rx_er <= er_p0;
                gmii_rx_v  <= 1'b1;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_LOW: begin
                        if (dv_p0) begin
                            low_nib_p1 <= nib_p0;
                            low_er_p1  <= er_p0;
                            gmii_rx_v  <= 1'b0;
                            state      <= S_HIGH;
                        end else begin
                            // Idle strobe keeps carrier/false-carrier visible.
                            gmii_rxd   <= 8'h00;
                            gmii_rx_dv <= 1'b0;
                            gmii_rx_er <= er_p0;
                            gmii_rx_v  <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end
                    S_HIGH: begin
                        if (dv_p0) begin
                            gmii_rxd   <= {nib_p0, low_nib_p1};
                            gmii_rx_dv <= 1'b1;
                            gmii_rx_er <= low_er_p1 | er_p0;
                            gmii_rx_v  <= 1'b1;
                            state      <= S_LOW;
                        end else begin
                            // Frame ended with only a low nibble: drop it.
                            gmii_rxd    <= 8'h00;
                            gmii_rx_dv  <= 1'b0;
                            gmii_rx_er  <= er_p0;
                            gmii_rx_v   <= 1'b1;
                            nib_err     <= 1'b1;
                            nib_err_cnt <= sat_inc(nib_err_cnt);
                            state       <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef RGMII_RX_INBAND_STATUS_EN
    // ---- in-band status: idle cycles with ctl low on both edges ----
    logic       stat_samp;
    logic [3:0] stat_prev;
    logic       stat_prev_vld;

    assign stat_samp = !rx_q1[4] && !rx_q2[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_prev_vld <= 1'b0;
            link_up       <= 1'b0;
            link_speed    <= 2'b00;
            full_duplex   <= 1'b0;
        end else if (stat_samp) begin
            stat_prev     <= nib_p0;
            stat_prev_vld <= 1'b1;
            // Two identical consecutive samples filter single-cycle glitches.
            if (stat_prev_vld && (stat_prev == nib_p0)) begin
                link_up     <= nib_p0[0];
                link_speed  <= nib_p0[2:1];
                full_duplex <= nib_p0[3];
            end
        end else begin
            stat_prev_vld <= 1'b0;
        end
    end
`else
    assign link_up     = 1'b0;
    assign link_speed  = 2'b00;
    assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_assembler.sv
module tb_rgmii_rx_assembler;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rx_q1;
    logic [4:0]    rx_q2;
    logic [1:0]    speed;
    logic [7:0]    gmii_rxd;
    logic          gmii_rx_dv;
    logic          gmii_rx_er;
    logic          gmii_rx_v;
    logic          nib_err;
    logic [CW-1:0] nib_err_cnt;
    logic          link_up;
    logic [1:0]    link_speed;
    logic          full_duplex;

    rgmii_rx_assembler #(.NIB_ERR_CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_q1       (rx_q1),
        .rx_q2       (rx_q2),
        .speed       (speed),
        .gmii_rxd    (gmii_rxd),
        .gmii_rx_dv  (gmii_rx_dv),
        .gmii_rx_er  (gmii_rx_er),
        .gmii_rx_v   (gmii_rx_v),
        .nib_err     (nib_err),
        .nib_err_cnt (nib_err_cnt),
        .link_up     (link_up),
        .link_speed  (link_speed),
        .full_duplex (full_duplex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] rxd;
        logic       dv;
        logic       er;
        logic       ne;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    // Scoreboard consumer: one expected entry per driven cycle, compared
    // after the edge that registers it.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests++;
            if ((gmii_rx_v !== mon_e.v) || (nib_err !== mon_e.ne) ||
                (mon_e.v && ({gmii_rxd, gmii_rx_dv, gmii_rx_er} !== {mon_e.rxd, mon_e.dv, mon_e.er}))) begin
                fails++;
                $display("FAIL stream @%0t: got v=%b rxd=%h dv=%b er=%b ne=%b, want v=%b rxd=%h dv=%b er=%b ne=%b",
                         $time, gmii_rx_v, gmii_rxd, gmii_rx_dv, gmii_rx_er, nib_err,
                         mon_e.v, mon_e.rxd, mon_e.dv, mon_e.er, mon_e.ne);
            end
        end
    end

    task automatic drive(input logic [4:0] q1, input logic [4:0] q2, input logic v,
                         input logic [7:0] rxd, input logic dv, input logic er, input logic ne);
        @(negedge clk);
        rx_q1 = q1;
        rx_q2 = q2;
        exp_q.push_back({v, rxd, dv, er, ne});
    endtask

    // All-zero idle cycles give the same strobe in every mode.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(5'h00, 5'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            @(posedge clk);
            k++;
        end
        #3;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        speed = 2'b10;
        rx_q1 = 5'h1F;
        rx_q2 = 5'h1F;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_v} !== 11'h0) begin
            fails++;
            $display("FAIL reset_byte: got rxd=%h dv=%b er=%b v=%b, want all 0", gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_rx_v);
        end
        tests++;
        if (nib_err !== 1'b0 || nib_err_cnt !== '0) begin
            fails++;
            $display("FAIL reset_nib: got nib_err=%b cnt=%0d, want 0 0", nib_err, nib_err_cnt);
        end
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'h0) begin
            fails++;
            $display("FAIL reset_status: got %b%b%b, want 0000", link_up, link_speed, full_duplex);
        end
        @(negedge clk);
        rst   = 1'b0;
        rx_q1 = 5'h00;
        rx_q2 = 5'h00;
        drain();
    endtask

    task automatic test_reset_mid_frame();
        speed = 2'b01;
        idle(2);
        drive(5'h17, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        rst   = 1'b1;
        rx_q1 = 5'h18;
        rx_q2 = 5'h10;
        @(posedge clk);
        #1;
        tests++;
        if (gmii_rx_v !== 1'b0 || nib_err !== 1'b0) begin
            fails++;
            $display("FAIL midreset_out: got v=%b nib_err=%b, want 0 0", gmii_rx_v, nib_err);
        end
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        drain();
        tests++;
        if (nib_err_cnt !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL midreset_cnt: got %0d, want %0d", nib_err_cnt, exp_cnt);
        end
    endtask

    task automatic test_1g_frame();
        speed = 2'b10;
        idle(2);
        for (int i = 0; i < 4; i++) drive(5'h15, 5'h1A, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(2);
        speed = 2'b11;
        idle(2);
        drive(5'h1C, 5'h13, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(1);
        drain();
    endtask

    task automatic test_100m_frame();
        speed = 2'b01;
        idle(2);
        drive(5'h15, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h1D, 5'h10, 1'b1, 8'hD5, 1'b1, 1'b0, 1'b0);
        idle(2);
        drain();
    endtask

    task automatic test_odd_nibble();
        speed = 2'b01;
        idle(1);
        drive(5'h11, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h12, 5'h10, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        drive(5'h13, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h00, 5'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        exp_cnt++;
        idle(1);
        drain();
        tests++;
        if (nib_err_cnt !== CW'(exp_cnt) || nib_err !== 1'b0) begin
            fails++;
            $display("FAIL odd_cnt: got cnt=%0d nib_err=%b, want %0d 0", nib_err_cnt, nib_err, exp_cnt);
        end
    endtask

    task automatic test_cnt_saturation();
        for (int i = 0; i < 8; i++) begin
            drive(5'h19, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            drive(5'h00, 5'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
        idle(1);
        drain();
        tests++;
        if (nib_err_cnt !== CW'(exp_cnt)) begin
            fails++;
            $display("FAIL sat_cnt: got %0d, want %0d", nib_err_cnt, exp_cnt);
        end
    endtask

    task automatic test_error_decode();
        speed = 2'b10;
        idle(2);
        drive(5'h13, 5'h0C, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
        drive(5'h15, 5'h1A, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        idle(1);
        drive(5'h00, 5'h10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1);
        speed = 2'b00;
        idle(2);
        drive(5'h14, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h18, 5'h00, 1'b1, 8'h84, 1'b1, 1'b1, 1'b0);
        drive(5'h16, 5'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h17, 5'h10, 1'b1, 8'h76, 1'b1, 1'b1, 1'b0);
        drive(5'h11, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h12, 5'h10, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        drive(5'h00, 5'h10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
        idle(1);
        drain();
    endtask

    task automatic test_speed_change();
        speed = 2'b01;
        idle(2);
        drive(5'h11, 5'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h12, 5'h10, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
        speed = 2'b10;
        drive(5'h13, 5'h1F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(5'h14, 5'h1F, 1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(5'h16, 5'h19, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
        drive(5'h16, 5'h19, 1'b1, 8'h96, 1'b1, 1'b0, 1'b0);
        idle(2);
        drain();
    endtask

    task automatic test_status();
        @(negedge clk);
        rx_q1 = 5'h0D;
        rx_q2 = 5'h00;
        @(posedge clk);
        #1;
`ifdef RGMII_RX_INBAND_STATUS_EN
        tests++;
        if (link_up !== 1'b0) begin
            fails++;
            $display("FAIL status_one_sample: got link_up=%b, want 0", link_up);
        end
`endif
        @(negedge clk);
        @(posedge clk);
        #1;
`ifdef RGMII_RX_INBAND_STATUS_EN
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
            fails++;
            $display("FAIL status_update: got %b%b%b, want 1101", link_up, link_speed, full_duplex);
        end
        @(negedge clk);
        rx_q1 = 5'h00;
        @(posedge clk);
        #1;
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
            fails++;
            $display("FAIL status_glitch: got %b%b%b, want 1101", link_up, link_speed, full_duplex);
        end
        @(negedge clk);
        rx_q1 = 5'h0D;
        @(posedge clk);
        #1;
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
            fails++;
            $display("FAIL status_after_glitch: got %b%b%b, want 1101", link_up, link_speed, full_duplex);
        end
        @(negedge clk);
        rx_q1 = 5'h10;
        rx_q2 = 5'h10;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'b1101) begin
            fails++;
            $display("FAIL status_freeze: got %b%b%b, want 1101", link_up, link_speed, full_duplex);
        end
`else
        tests++;
        if ({link_up, link_speed, full_duplex} !== 4'b0000) begin
            fails++;
            $display("FAIL status_tied: got %b%b%b, want 0000", link_up, link_speed, full_duplex);
        end
`endif
        @(negedge clk);
        rx_q1 = 5'h00;
        rx_q2 = 5'h00;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_frame();
        test_1g_frame();
        test_100m_frame();
        test_odd_nibble();
        test_cnt_saturation();
        test_error_decode();
        test_speed_change();
        test_status();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_assembler.md
Name: rgmii_rx_assembler

Overview:
Consumes the per-cycle rising/falling-edge samples produced by the source-synchronous DDR input stage on the RGMII receive path. The five sampled lines are RXD[3:0] and RX_CTL. It rebuilds a GMII-style byte stream with a byte-valid strobe for 1000 Mb/s (DDR) and 10/100 Mb/s (nibble-serial) modes, and decodes RX_DV/RX_ER from RX_CTL. It sits between the DDR input stage and the MAC receive FIFO, clocked by the recovered RX clock.

Parameters:
- NIB_ERR_CNT_W, 16, width of the saturating odd-nibble error counter

Ports:
- clk  input  1  recovered RGMII RX clock (output_clk of the DDR input stage)
- rst  input  1  synchronous, active-high reset
- rx_q1  input  5  rising-edge sample {ctl, d[3:0]}
- rx_q2  input  5  falling-edge sample {ctl, d[3:0]}
- speed  input  2  00=10M, 01=100M, 10=1G, 11=treated as 1G
- gmii_rxd  output  8  assembled byte
- gmii_rx_dv  output  1  data valid qualifier for the current byte
- gmii_rx_er  output  1  receive error qualifier for the current byte
- gmii_rx_v  output  1  byte strobe; the byte outputs are meaningful only when this is 1
- nib_err  output  1  one-cycle pulse when a frame ends on an odd nibble
- nib_err_cnt  output  NIB_ERR_CNT_W  saturating count of nib_err pulses
- link_up  output  1  in-band link status (optional feature)
- link_speed  output  2  in-band speed (optional feature)
- full_duplex  output  1  in-band duplex (optional feature)

Behaviour:
- Reset: all outputs 0; nibble phase = LOW; active_speed = 10 (1G).
- Decode per cycle: dv = rx_q1[4]; er = rx_q1[4] ^ rx_q2[4].
- active_speed:
  - Loads from speed only on cycles where the registered dv is 0 (idle).
  - A speed change mid-frame is ignored until the frame ends.
- 1G mode:
  - Every cycle: gmii_rxd = {rx_q2[3:0], rx_q1[3:0]}, gmii_rx_dv = dv, gmii_rx_er = er, gmii_rx_v = 1.
  - Latency is 1 clk (registered).
  - nib_err never asserts in this mode.
- 10/100 mode: one nibble per clk, taken from rx_q1[3:0]. FSM states:
  - IDLE: dv=0 -> gmii_rx_v=1 with dv=0, rxd=0, and er as decoded (carrier/false-carrier pass-through). dv=1 -> store nibble as low, go to HIGH; no strobe this cycle.
  - HIGH: dv=1 -> gmii_rxd = {nibble, stored_low}, gmii_rx_dv=1, gmii_rx_er = er_low | er_now, gmii_rx_v=1, go to LOW. dv=0 -> partial byte dropped, nib_err pulses, gmii_rx_v=1 with dv=0, go to IDLE.
  - LOW: dv=1 -> store nibble, go to HIGH, no strobe. dv=0 -> go to IDLE, gmii_rx_v=1 with dv=0.
  - Byte output appears 1 clk after the high-nibble sample.
- nib_err_cnt increments on each nib_err pulse and saturates at all-ones.
- Simultaneous speed change and frame end: the new speed applies from the next cycle, after the state returns to IDLE.
- Reset mid-frame: state returns to IDLE immediately and any partial byte is discarded without a nib_err pulse.

Optional Feature:
- Macro: RGMII_RX_INBAND_STATUS_EN.
- Defined:
  - A status sample is taken on idle cycles where rx_q1[4]=0 and rx_q2[4]=0.
  - Decode: link = d[0], speed = d[2:1], duplex = d[3].
  - The status is registered into link_up/link_speed/full_duplex only after two consecutive identical samples.
  - Updates freeze while dv=1.
- Not defined: link_up, link_speed and full_duplex are tied to 0 and no status logic is built.

Test Plan:
- 1G frame: speed=10, 4 cycles q1={1,0x5}, q2={1,0xA}, then idle -> gmii_rxd=0xA5 with dv=1, er=0, v=1 each cycle, 1-clk latency; dv=0 afterward.
- 100M frame: speed=01, nibbles 0x5,0xD with dv=1 -> one strobe with gmii_rxd=0xD5, dv=1; no strobe on the low-nibble cycle.
- Odd nibble end: 100M, 3 nibbles then dv=0 -> one byte emitted, nib_err pulses once, nib_err_cnt=1, next strobe has dv=0.
- Error decode: 1G, q1[4]=1, q2[4]=0 -> gmii_rx_er=1, gmii_rx_dv=1; 10M with er only on the high nibble -> byte er=1.
- Speed change mid-frame: switch speed 01->10 at frame byte 2 -> assembly stays nibble mode until dv=0, then 1G mode.
- Optional feature (macro defined): idle with ctl=0 and d=0xD for 2 cycles -> link_up=1, link_speed=10, full_duplex=1; a single-cycle glitch to 0x0 leaves the outputs unchanged.
